// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word and RAM handshake encodings plus the
// memory arbiter's grant state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ram_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_DGRANT = 2'd1,
    ARB_IGRANT = 2'd2
  } arb_state_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter_if.sv
// Cache-request and single-port RAM signals seen by the memory arbiter.
// slave is the arbiter's view; master is the caches-plus-RAM side.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // instruction cache side
  logic       iREN;
  word_t      iaddr;
  logic       iwait;
  word_t      iload;
  // data cache side
  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  logic       dwait;
  word_t      dload;
  // RAM side
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  ram_state_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// Serialises instruction and data cache requests onto one RAM port with a
// registered grant, alternating priority, abort on withdrawal and a watchdog.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  mem_arbiter_if.slave     bus,
  output logic             timeout
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(TIMEOUT);

  localparam logic LAST_INSTR = 1'b0;
  localparam logic LAST_DATA  = 1'b1;

  arb_state_t    state, next_state;
  logic          last, next_last;
  logic [CW-1:0] cnt, cnt_inc;
  logic          stalled;

  logic i_req, d_req;
  assign i_req = bus.iREN;
  assign d_req = bus.dREN | bus.dWEN;

  assign cnt_inc = (cnt == CNT_TOP) ? CNT_TOP : cnt + 1'b1;

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    next_state   = state;
    next_last    = last;
    stalled      = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (d_req && i_req)
          next_state = (last == LAST_INSTR) ? ARB_DGRANT : ARB_IGRANT;
        else if (d_req)
          next_state = ARB_DGRANT;
        else if (i_req)
          next_state = ARB_IGRANT;
      end

      ARB_DGRANT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dload    = bus.ramload;
        // A withdrawn request wins over a late ACCESS: nothing is completed.
        if (!d_req) begin
          next_state = ARB_IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait  = 1'b0;
          next_last  = LAST_DATA;
          next_state = i_req ? ARB_IGRANT : ARB_IDLE;
        end else begin
          stalled = 1'b1;
        end
      end

      ARB_IGRANT: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        bus.iload   = bus.ramload;
        if (!i_req) begin
          next_state = ARB_IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait  = 1'b0;
          next_last  = LAST_INSTR;
          next_state = d_req ? ARB_DGRANT : ARB_IDLE;
        end else begin
          stalled = 1'b1;
        end
      end

      default: next_state = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= ARB_IDLE;
      last    <= LAST_INSTR;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state <= next_state;
      last  <= next_last;
      if (stalled) begin
        cnt <= cnt_inc;
        if (cnt_inc == CNT_TOP)
          timeout <= 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for mem_arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  logic timeout;
  int   passed = 0;
  int   total  = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .bus     (bus),
    .timeout (timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       iren;
    word_t      iaddr;
    logic       dren;
    logic       dwen;
    word_t      daddr;
    word_t      dstore;
    ram_state_t rs;
    word_t      rload;
    logic [3:0] ctl;   // {iwait, dwait, ramREN, ramWEN}
    word_t      addr;
    word_t      store;
    word_t      iload;
    word_t      dload;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic drive(input logic iren, input word_t iaddr, input logic dren,
                       input logic dwen, input word_t daddr, input word_t dstore,
                       input ram_state_t rs, input word_t rload);
    bus.iREN     = iren;
    bus.iaddr    = iaddr;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.daddr    = daddr;
    bus.dstore   = dstore;
    bus.ramstate = rs;
    bus.ramload  = rload;
  endtask

  function automatic logic [3:0] ctl();
    return {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN};
  endfunction

  task automatic reset_dut();
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, FREE, 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    // Vector stream from reset: single instr read, data write with 3 BUSY,
    // dual request with last=DATA, dWEN precedence over dREN, ERROR as BUSY.
    vecs.push_back(vec_t'{1, 32'h40, 0, 0, 0, 0, FREE, 0, 4'b1100, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h2402000A, 4'b0110, 32'h40, 0, 32'h2402000A, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 32'h80, 32'hDEADBEEF, FREE, 32'h11111111, 4'b1100, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 1, 32'h80, 32'hDEADBEEF, BUSY, 32'h11111111, 4'b1101, 32'h80, 32'hDEADBEEF, 0, 32'h11111111});
    vecs.push_back(vec_t'{0, 0, 0, 1, 32'h80, 32'hDEADBEEF, BUSY, 32'h11111111, 4'b1101, 32'h80, 32'hDEADBEEF, 0, 32'h11111111});
    vecs.push_back(vec_t'{0, 0, 0, 1, 32'h80, 32'hDEADBEEF, BUSY, 32'h11111111, 4'b1101, 32'h80, 32'hDEADBEEF, 0, 32'h11111111});
    vecs.push_back(vec_t'{0, 0, 0, 1, 32'h80, 32'hDEADBEEF, ACCESS, 32'h11111111, 4'b1001, 32'h80, 32'hDEADBEEF, 0, 32'h11111111});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, FREE, 0, 4'b1100, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 32'h44, 1, 0, 32'h84, 0, FREE, 32'hCAFE0001, 4'b1100, 0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 32'h44, 1, 0, 32'h84, 0, ACCESS, 32'hCAFE0001, 4'b0110, 32'h44, 0, 32'hCAFE0001, 0});
    vecs.push_back(vec_t'{0, 0, 1, 0, 32'h84, 0, ACCESS, 32'hCAFE0002, 4'b1010, 32'h84, 0, 0, 32'hCAFE0002});
    vecs.push_back(vec_t'{0, 0, 1, 1, 32'h88, 32'h12345678, FREE, 0, 4'b1100, 0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 0, 1, 1, 32'h88, 32'h12345678, FREE, 0, 4'b1101, 32'h88, 32'h12345678, 0, 0});
    vecs.push_back(vec_t'{0, 0, 1, 1, 32'h88, 32'h12345678, ERROR, 0, 4'b1101, 32'h88, 32'h12345678, 0, 0});
    vecs.push_back(vec_t'{0, 0, 1, 1, 32'h88, 32'h12345678, ACCESS, 0, 4'b1001, 32'h88, 32'h12345678, 0, 0});
    vecs.push_back(vec_t'{0, 0, 0, 0, 0, 0, FREE, 0, 4'b1100, 0, 0, 0, 0});

    // Reset state, with an instruction request already pending.
    nRST = 1'b0;
    drive(1, 32'h40, 0, 0, 0, 0, FREE, 0);
    #12;
    check("rst_ctl", 32'(ctl()), 32'(4'b1100));
    check("rst_addr", bus.ramaddr, 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset_dut();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen,
            vecs[i].daddr, vecs[i].dstore, vecs[i].rs, vecs[i].rload);
      #1;
      check($sformatf("v%0d_ctl", i), 32'(ctl()), 32'(vecs[i].ctl));
      check($sformatf("v%0d_addr", i), bus.ramaddr, vecs[i].addr);
      check($sformatf("v%0d_store", i), bus.ramstore, vecs[i].store);
      check($sformatf("v%0d_iload", i), bus.iload, vecs[i].iload);
      check($sformatf("v%0d_dload", i), bus.dload, vecs[i].dload);
      @(negedge CLK);
    end

    // Both request from reset: data first, then instr with no IDLE bubble,
    // then data again since the instr side just completed.
    reset_dut();
    drive(1, 32'h200, 1, 0, 32'h300, 0, FREE, 0);
    #1 check("alt_idle", 32'(ctl()), 32'(4'b1100));
    @(negedge CLK);
    drive(1, 32'h200, 1, 0, 32'h300, 0, ACCESS, 32'hAAAA0001);
    #1 check("alt_d_ctl", 32'(ctl()), 32'(4'b1010));
    check("alt_d_addr", bus.ramaddr, 32'h300);
    check("alt_d_load", bus.dload, 32'hAAAA0001);
    @(negedge CLK);
    drive(1, 32'h200, 1, 0, 32'h300, 0, ACCESS, 32'hAAAA0002);
    #1 check("alt_i_ctl", 32'(ctl()), 32'(4'b0110));
    check("alt_i_addr", bus.ramaddr, 32'h200);
    check("alt_i_load", bus.iload, 32'hAAAA0002);
    @(negedge CLK);
    drive(0, 0, 1, 0, 32'h300, 0, BUSY, 0);
    #1 check("alt_d2_ctl", 32'(ctl()), 32'(4'b1110));
    check("alt_d2_addr", bus.ramaddr, 32'h300);
    @(negedge CLK);

    // Abort: data read withdrawn while BUSY.
    reset_dut();
    drive(0, 0, 1, 0, 32'h90, 0, BUSY, 0);
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("abort_wait%0d", k), 32'(bus.dwait), 32'h1);
      @(negedge CLK);
    end
    drive(0, 0, 0, 0, 32'h90, 0, BUSY, 0);
    #1 check("abort_cyc_ctl", 32'(ctl()), 32'(4'b1100));
    @(negedge CLK);
    #1 check("abort_idle_addr", bus.ramaddr, 32'h0);
    check("abort_cnt", 32'(dut.cnt), 32'h0);
    check("abort_timeout", 32'(timeout), 32'h0);
    @(negedge CLK);

    // Watchdog with TIMEOUT=8: IGRANT held BUSY.
    reset_dut();
    drive(1, 32'h100, 0, 0, 0, 0, BUSY, 0);
    @(negedge CLK);
    for (int k = 1; k <= 9; k++) begin
      #1 check($sformatf("wd_timeout%0d", k), 32'(timeout), (k == 9) ? 32'h1 : 32'h0);
      check($sformatf("wd_iwait%0d", k), 32'(bus.iwait), 32'h1);
      @(negedge CLK);
    end
    drive(1, 32'h100, 0, 0, 0, 0, ACCESS, 32'h5);
    #1 check("wd_access_iwait", 32'(bus.iwait), 32'h0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, FREE, 0);
    #1 check("wd_sticky", 32'(timeout), 32'h1);
    @(negedge CLK);

    // Asynchronous reset in the middle of a data write.
    reset_dut();
    drive(0, 0, 0, 1, 32'hA0, 32'h77, BUSY, 0);
    @(negedge CLK);
    #1 check("rmid_wen", 32'(bus.ramWEN), 32'h1);
    #1 nRST = 1'b0;
    #1 check("rmid_ctl", 32'(ctl()), 32'(4'b1100));
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, FREE, 0);
    nRST = 1'b1;
    #1 check("rmid_state", 32'(dut.state), 32'(ARB_IDLE));
    check("rmid_after_ctl", 32'(ctl()), 32'(4'b1100));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mem_arbiter
